// File: rtl/p_pkg.sv
// Shared definitions for the packed multi-precision add/subtract block.
//   - pack-width one-hot constants (s_pw bit [i] selects 2^(i+1)-bit lanes)
//   - FSM state encoding
//   - lane helpers used by the lane adder and by the top-level carry-in select
package p_pkg;

  localparam logic [4:0] PW2  = 5'b00001;
  localparam logic [4:0] PW4  = 5'b00010;
  localparam logic [4:0] PW8  = 5'b00100;
  localparam logic [4:0] PW16 = 5'b01000;
  localparam logic [4:0] PW32 = 5'b10000;

  // IDLE: next accepted beat opens a packet. BUSY: a packet is open.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when bit position b is the least-significant bit of a lane.
  // The smallest selected width wins; an empty pw behaves as one 32-bit lane.
  function automatic logic lane_start(input logic [4:0] pw, input logic [4:0] b);
    if (pw[0])      return (b[0]   == 1'b0);
    else if (pw[1]) return (b[1:0] == 2'b0);
    else if (pw[2]) return (b[2:0] == 3'b0);
    else if (pw[3]) return (b[3:0] == 4'b0);
    else            return (b      == 5'b0);
  endfunction

  // Single 32-bit lane: the only width where carries chain across limbs.
  function automatic logic is_pw32(input logic [4:0] pw);
    return (pw[3:0] == 4'b0);
  endfunction

endpackage

// File: rtl/p_mpaddsub_lane.sv
// Packed 32-bit lane adder, purely combinational.
//   lhs, rhs : 32-bit operands
//   sub      : subtract (rhs inverted, carry-in of every lane above lane 0 = 1)
//   cin      : carry-in into bit 0 (lane 0)
//   pw       : one-hot lane width
//   result   : per-lane sum, carries never cross a lane boundary
//   cout     : carry out of bit 31 (top lane)
module p_mpaddsub_lane
  import p_pkg::*;
(
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        sub,
  input  logic        cin,
  input  logic [4:0]  pw,
  output logic [31:0] result,
  output logic        cout
);

  logic [31:0] rhs_eff;

  assign rhs_eff = sub ? ~rhs : rhs;

  // Ripple chain that is re-seeded at each lane boundary: bit 0 takes cin,
  // every other lane start takes sub (the +1 of two's complement negation).
  always_comb begin : add_chain
    logic c;
    c      = 1'b0;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (lane_start(pw, 5'(i))) c = (i == 0) ? cin : sub;
      result[i] = lhs[i] ^ rhs_eff[i] ^ c;
      c         = (lhs[i] & rhs_eff[i]) | (c & (lhs[i] ^ rhs_eff[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/p_mpaddsub.sv
// Streaming multi-precision packed add/subtract.
// Packets of 32-bit limbs arrive LS limb first; each limb is split into
// lanes of 2/4/8/16/32 bits. In 32-bit mode the carry chains from limb to
// limb, otherwise lanes are independent.
//
// Handshake (both sides): a transfer happens on a rising g_clk edge where
// valid and ready are both high; valid holds its payload stable until then.
// s_ready depends only on registers and m_ready, never on s_valid.
//
// Ports:
//   g_clk, g_resetn               clock, async active-low reset
//   s_valid/s_ready               input limb handshake
//   s_lhs, s_rhs                  operand limbs
//   s_first, s_last               packet delimiters
//   s_sub, s_pw                   operation and lane width (first beat only)
//   m_valid/m_ready               result limb handshake
//   m_result, m_last, m_carry     result limb, final flag, carry of bit 31
//   m_index                       limb index within the packet
//   err, err_clr                  sticky protocol error and its clear
//   state_dbg                     current FSM state
module p_mpaddsub
  import p_pkg::*;
#(
  parameter  int MAXLIMBS = 16,
  localparam int IW       = $clog2(MAXLIMBS)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_lhs,
  input  logic [31:0]   s_rhs,
  input  logic          s_first,
  input  logic          s_last,
  input  logic          s_sub,
  input  logic [4:0]    s_pw,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_result,
  output logic          m_last,
  output logic          m_carry,
  output logic [IW-1:0] m_index,
  output logic          err,
  input  logic          err_clr,
  output state_t        state_dbg
);

  state_t        state, state_next;
  logic          sub_q;
  logic [4:0]    pw_q;
  logic          carry_q;
  logic [IW-1:0] nidx_q;
  logic          rdy_q;

  logic          accept;
  logic          start;
  logic          eff_sub;
  logic [4:0]    eff_pw;
  logic          cin;
  logic [IW-1:0] idx;
  logic          overflow;
  logic          err_set;
  logic [31:0]   lane_res;
  logic          lane_cout;

  // rdy_q holds s_ready low until the first edge after reset release.
  assign s_ready   = rdy_q & (~m_valid | m_ready);
  assign accept    = s_valid & s_ready;
  assign state_dbg = state;

  always_comb begin
    // A BUSY beat carrying s_first restarts as a new packet.
    start    = (state == IDLE) || s_first;
    eff_sub  = start ? s_sub : sub_q;
    eff_pw   = start ? s_pw  : pw_q;
    cin      = start ? s_sub : (is_pw32(pw_q) ? carry_q : sub_q);
    idx      = start ? '0 : nidx_q;
    overflow = (idx == IW'(MAXLIMBS - 1)) && !s_last;
    err_set  = accept && (((state == BUSY) && s_first) ||
                          ((state == IDLE) && !s_first) ||
                          overflow);
    state_next = state;
    if (accept) state_next = (s_last || overflow) ? IDLE : BUSY;
  end

  p_mpaddsub_lane u_lane (
    .lhs    (s_lhs),
    .rhs    (s_rhs),
    .sub    (eff_sub),
    .cin    (cin),
    .pw     (eff_pw),
    .result (lane_res),
    .cout   (lane_cout)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rdy_q    <= 1'b0;
      sub_q    <= 1'b0;
      pw_q     <= '0;
      carry_q  <= 1'b0;
      nidx_q   <= '0;
      m_valid  <= 1'b0;
      m_result <= '0;
      m_last   <= 1'b0;
      m_carry  <= 1'b0;
      m_index  <= '0;
      err      <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        sub_q    <= eff_sub;
        pw_q     <= eff_pw;
        carry_q  <= lane_cout;
        nidx_q   <= idx + 1'b1;
        m_valid  <= 1'b1;
        m_result <= lane_res;
        m_carry  <= lane_cout;
        m_last   <= s_last | overflow;
        m_index  <= idx;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      // A same-cycle error wins over the clear.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p_mpaddsub.sv
// Bench for p_mpaddsub: reset checks, table of directed vectors, hand-written
// backpressure / reset-while-busy sequences, then random packets checked
// against a big-integer / per-lane arithmetic model through an expected queue.
module tb_p_mpaddsub;
  import p_pkg::*;

  localparam int MAXLIMBS = 16;
  localparam int IW       = 4;
  localparam int W        = 32 + 1 + 1 + IW;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_lhs;
  logic [31:0]   s_rhs;
  logic          s_first;
  logic          s_last;
  logic          s_sub;
  logic [4:0]    s_pw;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_result;
  logic          m_last;
  logic          m_carry;
  logic [IW-1:0] m_index;
  logic          err;
  logic          err_clr;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit drv_done;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  p_mpaddsub #(.MAXLIMBS(MAXLIMBS)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_lhs     (s_lhs),
    .s_rhs     (s_rhs),
    .s_first   (s_first),
    .s_last    (s_last),
    .s_sub     (s_sub),
    .s_pw      (s_pw),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_result  (m_result),
    .m_last    (m_last),
    .m_carry   (m_carry),
    .m_index   (m_index),
    .err       (err),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        first;
    logic        last;
    logic        sub;
    logic [4:0]  pw;
    logic        clr;
    logic [31:0] res;
    logic        carry;
    logic        last_o;
    logic [3:0]  idx;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] lhs, rhs, input logic first, last, sub,
                              input logic [4:0] pw, input logic clr,
                              input logic [31:0] res, input logic carry, last_o,
                              input logic [3:0] idx, input logic e);
    vec_t v;
    v.lhs = lhs; v.rhs = rhs; v.first = first; v.last = last; v.sub = sub;
    v.pw = pw; v.clr = clr; v.res = res; v.carry = carry; v.last_o = last_o;
    v.idx = idx; v.err = e;
    return v;
  endfunction

  // Entered at posedge+1 with m_ready high; leaves at posedge+1.
  task automatic apply_vec(input vec_t v, input string name);
    s_valid = 1'b1; s_lhs = v.lhs; s_rhs = v.rhs; s_first = v.first;
    s_last = v.last; s_sub = v.sub; s_pw = v.pw; err_clr = v.clr;
    @(negedge g_clk);
    chk({name, ".s_ready"}, 32'(s_ready), 32'd1);
    @(posedge g_clk); #1;
    s_valid = 1'b0; err_clr = 1'b0;
    @(negedge g_clk);
    chk({name, ".m_valid"}, 32'(m_valid), 32'd1);
    chk({name, ".result"},  m_result, v.res);
    chk({name, ".carry"},   32'(m_carry), 32'(v.carry));
    chk({name, ".last"},    32'(m_last), 32'(v.last_o));
    chk({name, ".index"},   32'(m_index), 32'(v.idx));
    chk({name, ".err"},     32'(err), 32'(v.err));
    @(posedge g_clk); #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] pl[MAXLIMBS];
  logic [31:0] pr[MAXLIMBS];

  function automatic int unsigned pw_bits(input logic [4:0] pw);
    case (pw)
      PW2:     return 2;
      PW4:     return 4;
      PW8:     return 8;
      PW16:    return 16;
      default: return 32;
    endcase
  endfunction

  // Pushes the expected result limbs of one well-formed packet.
  task automatic model_packet(input int n, input bit sub, input logic [4:0] pw);
    logic [543:0] a, b, al, bl, s, mask;
    logic [31:0]  res;
    logic         c;
    int unsigned  w;
    longint unsigned m, x, y, v;
    w = pw_bits(pw);
    a = '0; b = '0;
    for (int k = 0; k < n; k++) begin
      a[32*k +: 32] = pl[k];
      b[32*k +: 32] = pr[k];
    end
    for (int k = 0; k < n; k++) begin
      if (w == 32) begin
        // Whole packet is one big integer; limb k sees the low k+1 limbs.
        mask = (544'd1 << (32 * (k + 1))) - 544'd1;
        al = a & mask;
        bl = b & mask;
        if (sub) begin
          s = al - bl;
          c = (al >= bl);
        end else begin
          s = al + bl;
          c = s[32 * (k + 1)];
        end
        res = s[32*k +: 32];
      end else begin
        m = (64'd1 << w) - 64'd1;
        res = '0;
        c = 1'b0;
        for (int j = 0; j < 32 / w; j++) begin
          x = (64'(pl[k]) >> (j * w)) & m;
          y = (64'(pr[k]) >> (j * w)) & m;
          v = sub ? ((x - y) & m) : ((x + y) & m);
          res = res | 32'(v << (j * w));
          c = sub ? (x >= y) : ((x + y) > m);
        end
      end
      exp_q.push_back({res, c, (k == n - 1) ? 1'b1 : 1'b0, IW'(k)});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge g_clk) begin
    if (mon_en && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rnd.unexpected actual=%h required=none", m_result);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({m_result, m_carry, m_last, m_index} !== e) begin
          errors++;
          $display("FAIL rnd.limb actual=%h/%b/%b/%0d required=%h/%b/%b/%0d",
                   m_result, m_carry, m_last, m_index,
                   e[W-1 -: 32], e[IW+1], e[IW], e[IW-1:0]);
        end
      end
    end
  end

  // Random driver: entered and left at posedge+1.
  task automatic send_beat(input logic [31:0] l, r, input logic f, la, sb,
                           input logic [4:0] pw, output bit ok);
    repeat ($urandom_range(0, 2)) begin @(posedge g_clk); #1; end
    s_valid = 1'b1; s_lhs = l; s_rhs = r; s_first = f; s_last = la;
    s_sub = sb; s_pw = pw;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge g_clk);
      if (s_ready) begin
        @(posedge g_clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge g_clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[$];

  initial begin
    logic [4:0] pws[5];
    bit ok;
    pws[0] = PW2; pws[1] = PW4; pws[2] = PW8; pws[3] = PW16; pws[4] = PW32;

    g_resetn = 1'b0; s_valid = 1'b0; s_lhs = '0; s_rhs = '0; s_first = 1'b0;
    s_last = 1'b0; s_sub = 1'b0; s_pw = PW32; m_ready = 1'b1; err_clr = 1'b0;

    // Reset state.
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst.m_valid", 32'(m_valid), 32'd0);
    chk("rst.m_result", m_result, 32'd0);
    chk("rst.m_index", 32'(m_index), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.state", 32'(state_dbg), 32'(IDLE));
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("rst.s_ready_hold", 32'(s_ready), 32'd0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("rst.s_ready_up", 32'(s_ready), 32'd1);
    @(posedge g_clk); #1;

    // Directed table.
    tbl.push_back(mk(32'hFFFFFFFF, 32'h1, 1, 0, 0, PW32, 0, 32'h0, 1, 0, 0, 0));
    tbl.push_back(mk(32'hFFFFFFFF, 32'h0, 0, 1, 0, PW32, 0, 32'h0, 1, 1, 1, 0));
    tbl.push_back(mk(32'h0, 32'h1, 1, 0, 1, PW32, 0, 32'hFFFFFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(32'h0, 32'h0, 0, 1, 1, PW32, 0, 32'hFFFFFFFF, 0, 1, 1, 0));
    tbl.push_back(mk(32'h01FF7F80, 32'h01010101, 1, 1, 0, PW8, 0, 32'h02008081, 0, 1, 0, 0));
    tbl.push_back(mk(32'h00010005, 32'h00020003, 1, 1, 1, PW16, 0, 32'hFFFF0002, 0, 1, 0, 0));
    tbl.push_back(mk(32'h88888888, 32'h88888888, 1, 1, 0, PW4, 0, 32'h0, 1, 1, 0, 0));
    tbl.push_back(mk(32'h0, 32'h55555555, 1, 1, 1, PW2, 0, 32'hFFFFFFFF, 0, 1, 0, 0));
    tbl.push_back(mk(32'h12345678, 32'h11111111, 1, 1, 0, PW32, 0, 32'h23456789, 0, 1, 0, 0));
    // s_first mid-packet: restart with carry-in = sub, not the held carry.
    tbl.push_back(mk(32'hFFFFFFFF, 32'h1, 1, 0, 0, PW32, 0, 32'h0, 1, 0, 0, 0));
    tbl.push_back(mk(32'h5, 32'h3, 1, 1, 0, PW32, 0, 32'h8, 0, 1, 0, 1));
    tbl.push_back(mk(32'h2, 32'h3, 1, 1, 0, PW32, 1, 32'h5, 0, 1, 0, 0));
    // IDLE beat without s_first plus err_clr: error wins, beat is a start.
    tbl.push_back(mk(32'h1, 32'h1, 0, 1, 1, PW32, 1, 32'h0, 1, 1, 0, 1));
    tbl.push_back(mk(32'h7, 32'h7, 1, 1, 1, PW32, 1, 32'h0, 1, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Packet running past MAXLIMBS without s_last.
    for (int i = 0; i < MAXLIMBS; i++)
      apply_vec(mk(32'(i), 32'h0, (i == 0), 0, 0, PW32, 0, 32'(i), 0,
                   (i == MAXLIMBS - 1), 4'(i), (i == MAXLIMBS - 1)),
                $sformatf("ovf%0d", i));
    apply_vec(mk(32'h9, 32'h1, 0, 1, 1, PW32, 1, 32'h8, 1, 1, 0, 1), "ovf_after");
    apply_vec(mk(32'h2, 32'h2, 1, 1, 0, PW32, 1, 32'h4, 0, 1, 0, 0), "ovf_clr");

    // Backpressure: m_ready low for 3 cycles mid-packet.
    m_ready = 1'b0;
    s_valid = 1'b1; s_lhs = 32'hFFFFFFFF; s_rhs = 32'h1; s_first = 1'b1;
    s_last = 1'b0; s_sub = 1'b0; s_pw = PW32;
    @(negedge g_clk);
    chk("bp.ready0", 32'(s_ready), 32'd1);
    @(posedge g_clk); #1;
    s_lhs = 32'h0; s_rhs = 32'h0; s_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      chk($sformatf("bp.stall_ready%0d", i), 32'(s_ready), 32'd0);
      chk($sformatf("bp.stall_res%0d", i), m_result, 32'h0);
      chk($sformatf("bp.stall_valid%0d", i), 32'(m_valid), 32'd1);
      @(posedge g_clk); #1;
    end
    m_ready = 1'b1;
    @(negedge g_clk);
    chk("bp.release_ready", 32'(s_ready), 32'd1);
    chk("bp.res0", m_result, 32'h0);
    chk("bp.carry0", 32'(m_carry), 32'd1);
    @(posedge g_clk); #1;
    s_lhs = 32'h7; s_rhs = 32'h1; s_last = 1'b1;
    @(negedge g_clk);
    chk("bp.res1", m_result, 32'h1);
    chk("bp.idx1", 32'(m_index), 32'd1);
    @(posedge g_clk); #1;
    s_valid = 1'b0;
    @(negedge g_clk);
    chk("bp.res2", m_result, 32'h8);
    chk("bp.idx2", 32'(m_index), 32'd2);
    chk("bp.last2", 32'(m_last), 32'd1);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("bp.drained", 32'(m_valid), 32'd0);
    @(posedge g_clk); #1;

    // Reset while BUSY with a result waiting (err set by a first-less start).
    m_ready = 1'b0;
    s_valid = 1'b1; s_lhs = 32'hFFFFFFFF; s_rhs = 32'h1; s_first = 1'b0;
    s_last = 1'b0; s_sub = 1'b0; s_pw = PW32;
    @(posedge g_clk); #1;
    s_valid = 1'b0;
    @(negedge g_clk);
    chk("rb.valid_before", 32'(m_valid), 32'd1);
    chk("rb.err_before", 32'(err), 32'd1);
    chk("rb.busy_before", 32'(state_dbg), 32'(BUSY));
    #2 g_resetn = 1'b0;
    #1;
    chk("rb.valid_after", 32'(m_valid), 32'd0);
    chk("rb.err_after", 32'(err), 32'd0);
    chk("rb.state_after", 32'(state_dbg), 32'(IDLE));
    @(posedge g_clk); #1;
    g_resetn = 1'b1; m_ready = 1'b1;
    @(posedge g_clk); #1;
    apply_vec(mk(32'h5, 32'h3, 1, 0, 0, PW32, 0, 32'h8, 0, 0, 0, 0), "rb.start");
    apply_vec(mk(32'h1, 32'h1, 0, 1, 0, PW32, 0, 32'h2, 0, 1, 1, 0), "rb.next");

    // Random packets against the model.
    mon_en = 1'b1;
    drv_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int n;
          bit sb;
          logic [4:0] pw;
          n  = $urandom_range(1, MAXLIMBS);
          sb = 1'($urandom_range(0, 1));
          pw = pws[$urandom_range(0, 4)];
          if ($urandom_range(0, 1) == 1) pw = PW32;
          for (int k = 0; k < n; k++) begin
            pl[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            pr[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          end
          model_packet(n, sb, pw);
          for (int k = 0; k < n; k++) begin
            send_beat(pl[k], pr[k], (k == 0), (k == n - 1), sb, pw, ok);
            chk("rnd.accept_timeout", 32'(ok), 32'd1);
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge g_clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge g_clk);
    @(negedge g_clk);
    chk("rnd.drain", 32'(exp_q.size()), 32'd0);
    chk("rnd.err", 32'(err), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
